// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int NUM_FLAGS  = 4;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine for multi-bit shifts and shift-add multiply. The final step
// is exposed combinationally (done/result) so the owner can capture it on the
// same edge the last iteration would have been registered.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0] CNT_ZERO = {(SHW+1){1'b0}};
  localparam logic [SHW:0] CNT_MUL  = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [SHW:0]     cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] step_s;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v,
                                                  input logic [3:0] sop);
    logic [WIDTH-1:0] r;
    case (sop)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Value the accumulator takes after one more iteration.
  always_comb begin
    step_s = acc_r;
    case (op_r)
      OP_MUL:                 step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
      OP_SLL, OP_SRL, OP_SRA: step_s = shift_once(acc_r, op_r);
      default:                step_s = acc_r;
    endcase
  end

  // Shifts perform their first bit at load, so only shamt-1 iterations remain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= CNT_ZERO;
      op_r     <= OP_AND;
    end else if (start) begin
      op_r <= op;
      if (op == OP_MUL) begin
        acc_r    <= {WIDTH{1'b0}};
        mcand_r  <= a;
        mplier_r <= b;
        cnt_r    <= CNT_MUL;
      end else begin
        acc_r <= shift_once(a, op);
        cnt_r <= {1'b0, b[SHW-1:0]} - CNT_ONE;
      end
    end else if (cnt_r != CNT_ZERO) begin
      acc_r    <= step_s;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  assign done   = (cnt_r == CNT_ONE);
  assign result = step_s;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shifts
// and multiply, with registered result and zero/neg/carry/overflow flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] muxA,
  input  logic [WIDTH-1:0] muxB,
  input  logic [3:0]       ALUControl,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] ALUout,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             carryFlag,
  output logic             ovfFlag
);

  localparam int SHW = $clog2(WIDTH);

  state_t                 state_r;
  logic                   out_valid_r;
  logic [WIDTH-1:0]       alu_out_r;
  logic [NUM_FLAGS-1:0]   flags_r;

  logic                   accept_s;
  logic                   long_shift_s;
  logic                   mul_op_s;
  logic                   iter_start_s;
  logic                   iter_done_s;
  logic [WIDTH-1:0]       iter_res_s;
  logic [WIDTH:0]         sum_s;
  logic [WIDTH:0]         diff_s;
  logic                   add_ovf_s;
  logic                   sub_ovf_s;
  logic [WIDTH-1:0]       res_s;
  logic                   carry_s;
  logic                   ovf_s;

  function automatic logic [NUM_FLAGS-1:0] make_flags(input logic [WIDTH-1:0] r,
                                                      input logic c,
                                                      input logic v);
    logic [NUM_FLAGS-1:0] f;
    f             = {NUM_FLAGS{1'b0}};
    f[FLAG_ZERO]  = (r == {WIDTH{1'b0}});
    f[FLAG_NEG]   = r[WIDTH-1];
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = v;
    return f;
  endfunction

  assign inReady      = (state_r == ST_IDLE) || ((state_r == ST_DONE) && outReady);
  assign accept_s     = inValid && inReady;
  // A one-bit shift is cheap enough to finish in the accept cycle like a simple op.
  assign long_shift_s = is_shift(ALUControl) && (muxB[SHW-1:1] != {(SHW-1){1'b0}});
  assign mul_op_s     = (ALUControl == OP_MUL);
  assign iter_start_s = accept_s && (long_shift_s || mul_op_s);

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .resetn (resetn),
    .start  (iter_start_s),
    .op     (ALUControl),
    .a      (muxA),
    .b      (muxB),
    .done   (iter_done_s),
    .result (iter_res_s)
  );

  // Single-cycle datapath; SUB/SLT/SLTU share the A+~B+1 adder.
  always_comb begin
    sum_s     = {1'b0, muxA} + {1'b0, muxB};
    diff_s    = {1'b0, muxA} + {1'b0, ~muxB} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf_s = (muxA[WIDTH-1] == muxB[WIDTH-1]) && (sum_s[WIDTH-1] != muxA[WIDTH-1]);
    sub_ovf_s = (muxA[WIDTH-1] != muxB[WIDTH-1]) && (diff_s[WIDTH-1] != muxA[WIDTH-1]);
    res_s     = {WIDTH{1'b0}};
    carry_s   = 1'b0;
    ovf_s     = 1'b0;
    case (ALUControl)
      OP_AND:  res_s = muxA & muxB;
      OP_OR:   res_s = muxA | muxB;
      OP_XOR:  res_s = muxA ^ muxB;
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = add_ovf_s;
      end
      OP_SUB: begin
        res_s   = diff_s[WIDTH-1:0];
        carry_s = diff_s[WIDTH];
        ovf_s   = sub_ovf_s;
      end
      OP_SLT: begin
        res_s   = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf_s};
        carry_s = diff_s[WIDTH];
      end
      OP_SLTU: begin
        res_s   = {{(WIDTH-1){1'b0}}, ~diff_s[WIDTH]};
        carry_s = diff_s[WIDTH];
      end
      OP_SLL:  res_s = muxA << muxB[0];
      OP_SRL:  res_s = muxA >> muxB[0];
      OP_SRA:  res_s = $signed(muxA) >>> muxB[0];
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM: handshake, result capture and hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      alu_out_r   <= {WIDTH{1'b0}};
      flags_r     <= {NUM_FLAGS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            if (long_shift_s) begin
              state_r     <= ST_SHIFT;
              out_valid_r <= 1'b0;
            end else if (mul_op_s) begin
              state_r     <= ST_MUL;
              out_valid_r <= 1'b0;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              alu_out_r   <= res_s;
              flags_r     <= make_flags(res_s, carry_s, ovf_s);
            end
          end else if ((state_r == ST_DONE) && outReady) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHIFT, ST_MUL: begin
          if (iter_done_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            alu_out_r   <= iter_res_s;
            flags_r     <= make_flags(iter_res_s, 1'b0, 1'b0);
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign outValid  = out_valid_r;
  assign ALUout    = alu_out_r;
  assign zeroFlag  = flags_r[FLAG_ZERO];
  assign negFlag   = flags_r[FLAG_NEG];
  assign carryFlag = flags_r[FLAG_CARRY];
  assign ovfFlag   = flags_r[FLAG_OVF];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results with their due
// cycle, a negedge monitor checks handshake, latency, values and flag hold.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        resetn, inValid, inReady, outValid, outReady;
  logic        zeroFlag, negFlag, carryFlag, ovfFlag;
  logic [31:0] muxA, muxB, ALUout;
  logic [3:0]  ALUControl;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .inValid(inValid), .inReady(inReady),
    .muxA(muxA), .muxB(muxB), .ALUControl(ALUControl),
    .outValid(outValid), .outReady(outReady), .ALUout(ALUout),
    .zeroFlag(zeroFlag), .negFlag(negFlag), .carryFlag(carryFlag), .ovfFlag(ovfFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  zncv;
    logic [3:0]  op;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;
  int   force_hold = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Reference: plain integer arithmetic; lat counts clock edges from accept to the
  // first edge at which outValid is sampled high.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int acc);
    exp_t   e;
    longint sa, sb, sr;
    logic [63:0] wide;
    int     sh, lat;
    logic   c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    e.res = 32'h0; c = 1'b0; v = 1'b0; lat = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b0010: begin
        wide = {32'h0, a} + {32'h0, b};
        e.res = wide[31:0]; c = wide[32];
        sr = sa + sb; v = (sr > SMAX) || (sr < SMIN);
      end
      4'b0110: begin
        e.res = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > SMAX) || (sr < SMIN);
      end
      4'b0111: begin e.res = (sa < sb) ? 32'd1 : 32'd0; c = (a >= b); end
      4'b1000: begin e.res = (a < b) ? 32'd1 : 32'd0; c = (a >= b); end
      4'b1001: begin e.res = a << sh; lat = (sh == 0) ? 1 : sh; end
      4'b1010: begin e.res = a >> sh; lat = (sh == 0) ? 1 : sh; end
      4'b1011: begin sr = sa >>> sh; e.res = sr[31:0]; lat = (sh == 0) ? 1 : sh; end
      4'b1100: begin wide = {32'h0, a} * {32'h0, b}; e.res = wide[31:0]; lat = 33; end
      default: e.res = 32'h0;
    endcase
    e.zncv = {(e.res == 32'h0), e.res[31], c, v};
    e.op   = op;
    e.due  = acc + lat - 1;
    return e;
  endfunction

  // Monitor: decoupled from stimulus, runs between negedge and the next posedge.
  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    #2;
    if (mon_en && resetn) begin
      exp_valid = (q.size() != 0) && (cyc >= q[0].due);
      exp_ready = (q.size() == 0) || (exp_valid && outReady);
      chk("outValid", {31'h0, outValid}, {31'h0, exp_valid});
      chk("inReady", {31'h0, inReady}, {31'h0, exp_ready});
      if (exp_valid && outValid) begin
        chk($sformatf("ALUout op=%b", q[0].op), ALUout, q[0].res);
        chk($sformatf("flags(zncv) op=%b", q[0].op),
            {28'h0, zeroFlag, negFlag, carryFlag, ovfFlag}, {28'h0, q[0].zncv});
        if (outReady) void'(q.pop_front());
      end
    end
  end

  task automatic set_ready();
    if (force_hold > 0) begin
      outReady = 1'b0;
      force_hold--;
    end else if (rand_ready) begin
      outReady = ($urandom_range(0, 3) != 0);
    end else begin
      outReady = 1'b1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc_ok = 1'b0;
    int acc_cyc = 0;
    int guard = 0;
    while (!acc_ok) begin
      @(negedge clk);
      set_ready();
      inValid = 1'b1; ALUControl = op; muxA = a; muxB = b;
      #1;
      if (inReady) begin
        acc_ok  = 1'b1;
        acc_cyc = cyc + 1;
      end
      @(posedge clk);
      #1;
      if (acc_ok) q.push_back(model(op, a, b, acc_cyc));
      inValid = 1'b0; muxA = $urandom; muxB = $urandom; ALUControl = 4'($urandom);
      guard++;
      if (!acc_ok && guard > 200) begin
        chk("accept timeout", 32'h0, 32'h1);
        return;
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(negedge clk);
      set_ready();
      guard++;
    end
    if (q.size() != 0) begin
      chk("drain timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " ALUout"}, ALUout, 32'h0);
    chk({tag, " flags"}, {28'h0, zeroFlag, negFlag, carryFlag, ovfFlag}, 32'h0);
    chk({tag, " outValid"}, {31'h0, outValid}, 32'h0);
    chk({tag, " inReady"}, {31'h0, inReady}, 32'h1);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [4];
    specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    resetn = 1'b0; inValid = 1'b0; outReady = 1'b0;
    muxA = 32'h0; muxB = 32'h0; ALUControl = 4'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_idle_outputs("reset");
    mon_en = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    drain();
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    drain();
    issue(4'b1011, 32'h8000_0000, 32'd4);
    drain();
    issue(4'b1001, 32'h1234_5678, 32'h0000_0020);
    issue(4'b1010, 32'h8765_4321, 32'd1);
    drain();
    issue(4'b1100, 32'h0000_FFFF, 32'h0001_0001);
    drain();
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1);
    drain();

    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    force_hold = 5;
    issue(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    drain();

    issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_idle_outputs("reset mid-MUL");

    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end
    rand_ready = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
